// File: rtl/da_accumulator.sv
// da_accumulator: 64-tap distributed-arithmetic FIR accumulator.
// Each cycle one bit-plane of all 64 tap samples arrives (LSB first).
// The coefficients selected by that bit-plane are summed into a partial sum.
// The partial sum is weighted by 2^k into the accumulator.
// The sign-bit plane is subtracted, giving two's-complement samples.
module da_accumulator #(
  parameter int CW = 16,
  parameter int SW = 16,
  parameter int OW = CW + 6 + SW
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [7:0]          A7,
  input  logic [7:0]          A6,
  input  logic [7:0]          A5,
  input  logic [7:0]          A4,
  input  logic [7:0]          A3,
  input  logic [7:0]          A2,
  input  logic [7:0]          A1,
  input  logic [7:0]          A0,
  input  logic                coef_we,
  input  logic [5:0]          coef_addr,
  input  logic [CW-1:0]       coef_data,
  output logic [OW-1:0]       y,
  output logic                y_valid,
  output logic                busy
);

  localparam int PW = CW + 6;            // partial-sum width, holds 64 * coef
  localparam logic [3:0] K_LAST = 4'(SW - 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                state;
  logic [3:0]            k;
  logic signed [OW-1:0]  acc;
  logic signed [CW-1:0]  coef [64];
  logic [63:0]           a_all;
  logic signed [PW-1:0]  p;
  logic signed [OW-1:0]  p_ext;

  // Tap n sits at bit n: A0 carries taps 0..7, A7 carries taps 56..63.
  assign a_all = {A7, A6, A5, A4, A3, A2, A1, A0};

  // Coefficient register file with single write port.
  // NOTE: the whole array is cleared on reset because a reset must leave every
  // coefficient at zero; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int n = 0; n < 64; n++) coef[n] <= '0;
    end else if (coef_we) begin
      coef[coef_addr] <= $signed(coef_data);
    end
  end

  // Partial sum of all coefficients whose tap bit is set this cycle.
  // NOTE: p gets a default before the loop so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    p = '0;
    for (int n = 0; n < 64; n++) begin
      if (a_all[n]) p = p + {{(PW-CW){coef[n][CW-1]}}, coef[n]};
    end
  end

  assign p_ext = {{(OW-PW){p[PW-1]}}, p};

  // Frame FSM: start (re)loads the accumulator with bit plane 0.
  // Middle planes add with weight 2^k; the sign plane subtracts and publishes y.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      k       <= '0;
      acc     <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      busy    <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      if (start) begin
        state <= ACCUM;
        acc   <= p_ext;
        k     <= 4'd1;
        busy  <= 1'b1;
      end else if (state == ACCUM) begin
        if (k == K_LAST) begin
          y       <= acc - (p_ext <<< (SW - 1));
          y_valid <= 1'b1;
          state   <= IDLE;
          busy    <= 1'b0;
          k       <= '0;
        end else begin
          acc <= acc + (p_ext <<< k);
          k   <= k + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_da_accumulator.sv
// Testbench for da_accumulator: directed scenarios plus random frames.
// Checking goes through a scoreboard of expected results popped by a monitor.
module tb_da_accumulator;

  localparam int CW = 16;
  localparam int SW = 16;
  localparam int OW = CW + 6 + SW;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [7:0]    a_bus [8];
  logic          coef_we;
  logic [5:0]    coef_addr;
  logic [CW-1:0] coef_data;
  logic [OW-1:0] y;
  logic          y_valid;
  logic          busy;

  da_accumulator #(.CW(CW), .SW(SW), .OW(OW)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .A7(a_bus[7]), .A6(a_bus[6]), .A5(a_bus[5]), .A4(a_bus[4]),
    .A3(a_bus[3]), .A2(a_bus[2]), .A1(a_bus[1]), .A0(a_bus[0]),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .y(y), .y_valid(y_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint y;
    int     at_edge;
  } exp_t;

  exp_t        sb [$];
  longint      mcoef [64];
  logic [15:0] xs [64];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: dot product of coefficients and signed samples.
  function automatic longint model_y();
    longint s = 0;
    for (int n = 0; n < 64; n++) s += mcoef[n] * longint'($signed(xs[n]));
    return s;
  endfunction

  // Monitor: every y_valid must match the next expected result, on time.
  always @(negedge clk) begin
    if (y_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_y_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("y_value", longint'($signed(y)), e.y);
        check("y_valid_edge", cyc, e.at_edge);
      end
    end
  end

  task automatic write_coef(input int addr, input longint val);
    coef_we   = 1'b1;
    coef_addr = 6'(addr);
    coef_data = CW'(val);
    @(negedge clk);
    coef_we   = 1'b0;
    mcoef[addr] = val;
  endtask

  // Stream nbits bit-planes of xs; start rides with bit 0.
  // push=1 queues the expected result of a full frame.
  task automatic drive_bits(input int nbits, input bit push);
    if (push) begin
      exp_t e;
      e.y = model_y();
      e.at_edge = cyc + 1 + (SW - 1);
      sb.push_back(e);
    end
    for (int b = 0; b < nbits; b++) begin
      start = (b == 0);
      for (int n = 0; n < 64; n++) a_bus[n / 8][n % 8] = xs[n][b];
      @(negedge clk);
      check("busy", longint'(busy), longint'(b != SW - 1));
    end
    start = 1'b0;
    for (int g = 0; g < 8; g++) a_bus[g] = '0;
  endtask

  // Idle cycles with random tap bits, which the DUT must ignore.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      for (int g = 0; g < 8; g++) a_bus[g] = 8'($urandom);
      @(negedge clk);
    end
    for (int g = 0; g < 8; g++) a_bus[g] = '0;
  endtask

  task automatic clear_xs();
    for (int n = 0; n < 64; n++) xs[n] = '0;
  endtask

  initial begin
    resetn    = 1'b0;
    start     = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    for (int g = 0; g < 8; g++) a_bus[g] = '0;
    for (int n = 0; n < 64; n++) mcoef[n] = 0;
    clear_xs();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_y", longint'($signed(y)), 0);
    check("rst_y_valid", longint'(y_valid), 0);
    check("rst_busy", longint'(busy), 0);
    resetn = 1'b1;
    @(negedge clk);

    // All A bits set, all coefficients zero -> 0
    for (int n = 0; n < 64; n++) xs[n] = 16'hFFFF;
    drive_bits(SW, 1);
    idle(2);

    // Single tap: 3 * 5
    write_coef(0, 3);
    clear_xs();
    xs[0] = 16'd5;
    drive_bits(SW, 1);
    idle(2);

    // Sign bit: -2 * -1 on tap 63
    write_coef(63, -2);
    clear_xs();
    xs[63] = 16'hFFFF;
    drive_bits(SW, 1);
    idle(2);

    // Full scale: 64 * 32767 * -32768
    for (int n = 0; n < 64; n++) write_coef(n, 32767);
    for (int n = 0; n < 64; n++) xs[n] = 16'h8000;
    drive_bits(SW, 1);
    idle(2);

    // Restart at cycle 7: only the second frame reports
    write_coef(5, 1);
    for (int n = 0; n < 64; n++) xs[n] = 16'($urandom);
    drive_bits(7, 0);
    clear_xs();
    xs[5] = 16'd100;
    drive_bits(SW, 1);
    idle(2);

    // start on the final-bit edge: completing frame is dropped
    for (int n = 0; n < 64; n++) xs[n] = 16'($urandom);
    drive_bits(SW - 1, 0);
    for (int n = 0; n < 64; n++) xs[n] = 16'($urandom);
    drive_bits(SW, 1);
    idle(2);

    // Random coefficients and frames, with occasional aborts and gaps
    for (int it = 0; it < 20; it++) begin
      for (int w = 0; w < int'($urandom_range(0, 6)); w++)
        write_coef(int'($urandom_range(0, 63)), longint'($signed(16'($urandom))));
      if ($urandom_range(0, 3) == 0) begin
        for (int n = 0; n < 64; n++) xs[n] = 16'($urandom);
        drive_bits(int'($urandom_range(1, SW - 1)), 0);
      end
      for (int n = 0; n < 64; n++) xs[n] = 16'($urandom);
      drive_bits(SW, 1);
      idle(int'($urandom_range(0, 3)));
    end
    idle(2);

    // Async reset mid-frame, between clock edges
    for (int n = 0; n < 64; n++) xs[n] = 16'($urandom);
    drive_bits(9, 0);
    #2 resetn = 1'b0;
    #1;
    check("arst_y", longint'($signed(y)), 0);
    check("arst_y_valid", longint'(y_valid), 0);
    check("arst_busy", longint'(busy), 0);
    for (int n = 0; n < 64; n++) mcoef[n] = 0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    idle(30);
    // Coefficients cleared: any frame yields 0
    for (int n = 0; n < 64; n++) xs[n] = 16'($urandom);
    drive_bits(SW, 1);

    // Drain with bound
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", longint'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
